// File: rtl/key_event_pkg.sv
// Shared constants and types for the push-button event latch.
package key_event_pkg;

   localparam int unsigned NUM_KEYS          = 2;
   localparam int unsigned KEY_HIGH_IDX      = 0;
   localparam int unsigned KEY_LOW_IDX       = 1;
   localparam int unsigned DEBOUNCE_BITS_DEF = 16;
   localparam int unsigned REPEAT_EN_DEF     = 0;
   localparam int unsigned HOLD_BITS_DEF     = 24;
   localparam int unsigned REPEAT_BITS_DEF   = 22;

   typedef enum logic {
      PH_HOLD   = 1'b0,
      PH_REPEAT = 1'b1
   } rpt_phase_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, debounce counter, debounced level,
// press pulse and optional auto-repeat timer.
module key_debounce
   import key_event_pkg::*;
#(
   parameter int unsigned DEBOUNCE_BITS = DEBOUNCE_BITS_DEF,
   parameter int unsigned REPEAT_EN     = REPEAT_EN_DEF,
   parameter int unsigned HOLD_BITS     = HOLD_BITS_DEF,
   parameter int unsigned REPEAT_BITS   = REPEAT_BITS_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_n_i,
   output logic level_o,
   output logic event_c_o
);

   localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;

   logic [1:0]               sync_q;
   logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
   logic                     level_q, level_d;
   logic                     differs, toggle, rise_c, fall_c, rpt_c;

   // Raw key is active-low; flops idle at 1 (released).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], key_n_i};
   end

   always_comb begin
      differs = ((~sync_q[1]) != level_q);
      toggle  = differs && (cnt_q == DB_MAX);
      cnt_d   = (differs && !toggle) ? cnt_q + DEBOUNCE_BITS'(1) : '0;
      level_d = level_q ^ toggle;
      rise_c  = toggle & ~level_q;
      fall_c  = toggle & level_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   if (REPEAT_EN != 0) begin : g_rpt
      localparam int unsigned CW = max_u(HOLD_BITS, REPEAT_BITS);
      localparam logic [CW-1:0] HOLD_MAX = CW'((64'd1 << HOLD_BITS) - 64'd1);
      localparam logic [CW-1:0] REP_MAX  = CW'((64'd1 << REPEAT_BITS) - 64'd1);

      rpt_phase_e    phase_q, phase_d;
      logic [CW-1:0] hcnt_q, hcnt_d;
      logic          fire;

      // Counter restarts on each press; first terminal count is the hold delay,
      // later ones are the repeat period.
      always_comb begin
         phase_d = phase_q;
         hcnt_d  = hcnt_q;
         fire    = 1'b0;
         if (rise_c || !level_q || fall_c) begin
            phase_d = PH_HOLD;
            hcnt_d  = '0;
         end else if (hcnt_q == ((phase_q == PH_HOLD) ? HOLD_MAX : REP_MAX)) begin
            fire    = 1'b1;
            phase_d = PH_REPEAT;
            hcnt_d  = '0;
         end else begin
            hcnt_d  = hcnt_q + CW'(1);
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            phase_q <= PH_HOLD;
            hcnt_q  <= '0;
         end else begin
            phase_q <= phase_d;
            hcnt_q  <= hcnt_d;
         end
      end

      assign rpt_c = fire;
   end else begin : g_no_rpt
      assign rpt_c = 1'b0;
   end

   assign level_o   = level_q;
   assign event_c_o = rise_c | rpt_c;

endmodule

// File: rtl/key_event_latch.sv
// Two debounced push buttons feeding a single-slot event latch that a game
// tick consumes; KEY[0] wins when both fire together.
module key_event_latch
   import key_event_pkg::*;
#(
   parameter int unsigned DEBOUNCE_BITS = DEBOUNCE_BITS_DEF,
   parameter int unsigned REPEAT_EN     = REPEAT_EN_DEF,
   parameter int unsigned HOLD_BITS     = HOLD_BITS_DEF,
   parameter int unsigned REPEAT_BITS   = REPEAT_BITS_DEF
) (
   input  logic                MAX10_CLK1_50,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] KEY,
   input  logic                consume,
   output logic                pressed_high,
   output logic                pressed_low,
   output logic [NUM_KEYS-1:0] key_level,
   output logic                overrun
);

   logic [NUM_KEYS-1:0] lvl;
   logic [NUM_KEYS-1:0] ev_c;
   logic                ph_q, ph_d, pl_q, pl_d, ov_q, ov_d;
   logic                ev_h, ev_l;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_BITS (DEBOUNCE_BITS),
         .REPEAT_EN     (REPEAT_EN),
         .HOLD_BITS     (HOLD_BITS),
         .REPEAT_BITS   (REPEAT_BITS)
      ) u_db (
         .clk_i     (MAX10_CLK1_50),
         .rst_i     (rst),
         .key_n_i   (KEY[k]),
         .level_o   (lvl[k]),
         .event_c_o (ev_c[k])
      );
   end

   // Clear on consume first, then the freed slot may take a new event.
   always_comb begin
      ph_d = ph_q;
      pl_d = pl_q;
      ov_d = ov_q;
      ev_h = ev_c[KEY_HIGH_IDX];
      ev_l = ev_c[KEY_LOW_IDX];
      if (consume && (ph_q || pl_q)) begin
         ph_d = 1'b0;
         pl_d = 1'b0;
         ov_d = 1'b0;
      end
      if (!(ph_d || pl_d)) begin
         if (ev_h) begin
            ph_d = 1'b1;
            ov_d = ev_l;
         end else if (ev_l) begin
            pl_d = 1'b1;
         end
      end else if (ev_h || ev_l) begin
         ov_d = 1'b1;
      end
   end

   always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
      if (rst) begin
         ph_q <= 1'b0;
         pl_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         ph_q <= ph_d;
         pl_q <= pl_d;
         ov_q <= ov_d;
      end
   end

   assign pressed_high = ph_q;
   assign pressed_low  = pl_q;
   assign overrun      = ov_q;
   assign key_level    = lvl;

endmodule

// File: doc/key_event_latch.md
KEY_EVENT_LATCH -- requirements
Module: key_event_latch

Interface
REQ-001 SHALL have parameter DEBOUNCE_BITS, default 16; input must hold stable for 2^DEBOUNCE_BITS consecutive cycles before the debounced level changes.
REQ-002 SHALL have parameter REPEAT_EN, default 0; 1 enables auto-repeat of held keys.
REQ-003 SHALL have parameter HOLD_BITS, default 24; cycles held (2^HOLD_BITS) after a press before the first repeat.
REQ-004 SHALL have parameter REPEAT_BITS, default 22; repeat period of 2^REPEAT_BITS cycles.
REQ-005 SHALL have port MAX10_CLK1_50, input, 1 bit: the single clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port KEY, input, 2 bits: raw push buttons, active-low, asynchronous to the clock.
REQ-008 SHALL have port consume, input, 1 bit: game-tick pulse; acknowledges and clears the pending event.
REQ-009 SHALL have port pressed_high, output, 1 bit: pending event from KEY[0].
REQ-010 SHALL have port pressed_low, output, 1 bit: pending event from KEY[1].
REQ-011 SHALL have port key_level, output, 2 bits: debounced state, active-high (1 = held).
REQ-012 SHALL have port overrun, output, 1 bit: a press was dropped while an event was pending.

Function
REQ-013 SHALL pass each KEY bit through a 2-flop synchronizer before any other logic.
REQ-014 SHALL keep one debounce counter per key, DEBOUNCE_BITS wide, cleared in any cycle where the synchronized input equals key_level.
REQ-015 SHALL increment the counter while the synchronized input differs from key_level; on the cycle it is all-ones and still differs, key_level SHALL toggle and the counter SHALL clear.
REQ-016 SHALL generate a press event on the same edge key_level goes 0->1; releases generate no event.
REQ-017 SHALL hold at most one pending event: pressed_high and pressed_low are never both 1.
REQ-018 SHALL, when both keys generate events in the same cycle with nothing pending, latch pressed_high and drop the low event (overrun set).
REQ-019 SHALL, when an event arrives while one is pending and consume=0, keep the existing event and set overrun.
REQ-020 SHALL clear pressed_high, pressed_low and overrun on the edge where consume=1.
REQ-021 SHALL, when consume and a new event coincide, apply the clear first and then latch the new event; overrun stays 0.
REQ-022 SHALL ignore consume while nothing is pending (no state change).
REQ-023 SHALL, with REPEAT_EN=1, count cycles a key stays held after its press; at 2^HOLD_BITS it issues a repeat event, then one every 2^REPEAT_BITS cycles; the count resets when key_level falls.
REQ-024 SHALL give repeat events the same latch and priority rules as press events.
REQ-025 SHALL make all outputs registered; latency from first sampled KEY low (stable) to pressed_* high is exactly 2 + 2^DEBOUNCE_BITS edges.

Reset
REQ-026 SHALL, while rst=1, hold synchronizer flops at 1 (released) and clear counters, key_level=2'b00, pressed_high=0, pressed_low=0, overrun=0.
REQ-027 SHALL, when rst asserts mid-debounce or with an event pending, discard it; a key held through reset release produces a fresh press event after the full latency.

Structure
REQ-028 SHALL take KEY_HIGH_IDX=0, KEY_LOW_IDX=1 and the default parameter values from shared package key_event_pkg.
REQ-029 SHALL instantiate sub-module key_debounce (synchronizer, counter, level, rise pulse, repeat timer) once per key; priority, latch and overrun logic sit in the top.

Verification (DEBOUNCE_BITS=4, HOLD_BITS=6, REPEAT_BITS=4)
REQ-030 SHALL cover: KEY[0] low stable -> pressed_high=1 at edge 18, key_level=2'b01; consume pulse -> pressed_high=0 next edge.
REQ-031 SHALL cover: KEY[1] bouncing every 5 cycles for 40 cycles then low -> no event during bounce; single pressed_low 18 edges after settling.
REQ-032 SHALL cover: both keys low on same cycle -> pressed_high=1, pressed_low=0, overrun=1.
REQ-033 SHALL cover: press event on same edge as consume with pressed_low pending -> pressed_low=0, new event latched, overrun=0.
REQ-034 SHALL cover: REPEAT_EN=1, KEY[0] held 200 cycles with consume every cycle -> events at edges 18, 82, 98, 114, ...
REQ-035 SHALL cover: rst pulsed at edge 10 of a debounce and again with pressed_high=1 -> all outputs 0 immediately; held key re-detected 18 edges after rst falls.
